// File: rtl/count_arbiter.sv
// Round-robin arbiter sharing one mod-10 up/down step counter among N requesters.
// A granted requester steps the counter once per cycle for its burst length.
module count_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_mode,
  input  logic [4*N-1:0] req_len,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           done,
  output logic [IDW-1:0] done_id,
  output logic [3:0]     number,
  output logic           zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, n_state;
  logic [IDW-1:0] ptr, n_ptr;
  logic [IDW-1:0] idx, n_idx;
  logic           mode, n_mode;
  logic [3:0]     rem, n_rem;
  logic [N-1:0]   n_grant;
  logic           n_busy, n_done;
  logic [IDW-1:0] n_done_id;
  logic [3:0]     n_number;
  logic           n_zero;

  logic           found;
  logic [IDW-1:0] win, cand;
  logic [3:0]     win_len;
  logic [3:0]     stepped;

  // Search upward from ptr+1 so the last served requester ranks lowest.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int j = 1; j <= N; j++) begin
      cand = IDW'((int'(ptr) + j) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_len = req_len[4*win +: 4];

  always_comb begin
    stepped = number;
    if (mode)
      stepped = (number == 4'd9) ? 4'd0 : number + 4'd1;
    else
      stepped = (number == 4'd0) ? 4'd9 : number - 4'd1;
  end

  always_comb begin
    n_state   = state;
    n_ptr     = ptr;
    n_idx     = idx;
    n_mode    = mode;
    n_rem     = rem;
    n_grant   = grant;
    n_busy    = busy;
    n_done    = 1'b0;
    n_done_id = done_id;
    n_number  = number;
    n_zero    = zero;
    unique case (state)
      IDLE: begin
        if (found) begin
          n_idx  = win;
          n_mode = req_mode[win];
          n_rem  = win_len;
          n_busy = 1'b1;
          if (win_len != 4'd0) begin
            n_grant = N'(1) << win;
            n_state = RUN;
          end else begin
            n_done    = 1'b1;
            n_done_id = win;
            n_state   = DONE;
          end
        end
      end
      RUN: begin
        n_number = stepped;
        n_zero   = (stepped == 4'd0);
        n_rem    = rem - 4'd1;
        if (rem == 4'd1) begin
          n_grant   = '0;
          n_done    = 1'b1;
          n_done_id = idx;
          n_state   = DONE;
        end
      end
      DONE: begin
        n_busy  = 1'b0;
        n_ptr   = idx;
        n_state = IDLE;
      end
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= IDW'(N - 1);
      idx     <= '0;
      mode    <= 1'b0;
      rem     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      number  <= '0;
      zero    <= 1'b1;
    end else begin
      state   <= n_state;
      ptr     <= n_ptr;
      idx     <= n_idx;
      mode    <= n_mode;
      rem     <= n_rem;
      grant   <= n_grant;
      busy    <= n_busy;
      done    <= n_done;
      done_id <= n_done_id;
      number  <= n_number;
      zero    <= n_zero;
    end
  end

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter: bursts, wraps, round-robin order,
// ignored mid-burst changes, zero-length requests and mid-burst reset.
module tb_count_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_mode;
  logic [4*N-1:0] req_len;
  logic [N-1:0]   grant;
  logic           busy;
  logic           done;
  logic [IDW-1:0] done_id;
  logic [3:0]     number;
  logic           zero;

  int checks = 0;
  int errors = 0;

  count_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_mode (req_mode),
    .req_len  (req_len),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .number   (number),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [3:0] num);
    chk({tag, " grant"}, 32'(grant), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " number"}, 32'(number), 32'(num));
    chk({tag, " zero"}, 32'(zero), 32'(num == 4'd0));
  endtask

  int rr_order [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_mode = '0;
    req_len  = '0;
    #12;
    chk_idle("reset", 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk_idle("post_reset", 4'd0);

    // Up burst: requester 0, len 3, 0 -> 1,2,3
    req = 4'b0001; req_mode = 4'b0001; req_len = 16'h0003;
    tick();
    chk("up grant", 32'(grant), 32'h1);
    chk("up busy", 32'(busy), 32'd1);
    chk("up num0", 32'(number), 32'd0);
    req = '0;
    tick();
    chk("up num1", 32'(number), 32'd1);
    chk("up zero1", 32'(zero), 32'd0);
    chk("up grant1", 32'(grant), 32'h1);
    tick();
    chk("up num2", 32'(number), 32'd2);
    chk("up done2", 32'(done), 32'd0);
    tick();
    chk("up num3", 32'(number), 32'd3);
    chk("up grant_off", 32'(grant), 32'h0);
    chk("up done", 32'(done), 32'd1);
    chk("up done_id", 32'(done_id), 32'd0);
    chk("up busy_done", 32'(busy), 32'd1);
    tick();
    chk_idle("up end", 4'd3);

    // Down len 2 on requester 2: 3 -> 2 -> 1
    req = 4'b0100; req_mode = 4'b0000; req_len = 16'h0200;
    tick();
    chk("dn grant", 32'(grant), 32'h4);
    req = '0;
    tick();
    chk("dn num2", 32'(number), 32'd2);
    tick();
    chk("dn num1", 32'(number), 32'd1);
    chk("dn done_id", 32'(done_id), 32'd2);
    tick();

    // Down wrap: 1 -> 0 -> 9 -> 8
    req = 4'b0100; req_len = 16'h0300;
    tick();
    chk("wrap grant", 32'(grant), 32'h4);
    req = '0;
    tick();
    chk("wrap num0", 32'(number), 32'd0);
    chk("wrap zero0", 32'(zero), 32'd1);
    tick();
    chk("wrap num9", 32'(number), 32'd9);
    chk("wrap zero9", 32'(zero), 32'd0);
    tick();
    chk("wrap num8", 32'(number), 32'd8);
    chk("wrap done", 32'(done), 32'd1);
    chk("wrap done_id", 32'(done_id), 32'd2);
    tick();
    chk_idle("wrap end", 4'd8);
    chk("wrap id_hold", 32'(done_id), 32'd2);

    // Reset restores ptr so requester 0 wins first
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("rst2", 4'd0);

    req = 4'b1011; req_mode = 4'b1111; req_len = 16'h1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr%0d grant", i), 32'(grant), 32'(1 << rr_order[i]));
      tick();
      chk($sformatf("rr%0d done", i), 32'(done), 32'd1);
      chk($sformatf("rr%0d id", i), 32'(done_id), 32'(rr_order[i]));
      chk($sformatf("rr%0d num", i), 32'(number), 32'(i + 1));
      chk($sformatf("rr%0d gnt_off", i), 32'(grant), 32'd0);
      if (i == 5) req = '0;
      tick();
      chk($sformatf("rr%0d busy_off", i), 32'(busy), 32'd0);
    end

    // Mid-burst changes ignored: requester 1 up len 5 from 6
    req = 4'b0010; req_mode = 4'b0010; req_len = 16'h0050;
    tick();
    chk("mid grant", 32'(grant), 32'h2);
    tick();
    chk("mid num7", 32'(number), 32'd7);
    tick();
    chk("mid num8", 32'(number), 32'd8);
    req = '0; req_mode = '0;
    tick();
    chk("mid num9", 32'(number), 32'd9);
    chk("mid grant3", 32'(grant), 32'h2);
    chk("mid nodone", 32'(done), 32'd0);
    tick();
    chk("mid num0", 32'(number), 32'd0);
    chk("mid zero", 32'(zero), 32'd1);
    chk("mid nodone2", 32'(done), 32'd0);
    tick();
    chk("mid num1", 32'(number), 32'd1);
    chk("mid done", 32'(done), 32'd1);
    chk("mid done_id", 32'(done_id), 32'd1);
    tick();
    chk_idle("mid end", 4'd1);

    // len=0 request: done pulse only
    req = 4'b0001; req_mode = 4'b0001; req_len = 16'h0000;
    tick();
    chk("z done", 32'(done), 32'd1);
    chk("z busy", 32'(busy), 32'd1);
    chk("z grant", 32'(grant), 32'd0);
    chk("z done_id", 32'(done_id), 32'd0);
    chk("z num", 32'(number), 32'd1);
    req = '0;
    tick();
    chk_idle("z end", 4'd1);

    // Reset during third step of a len=8 burst
    req = 4'b0001; req_len = 16'h0008;
    tick();
    chk("rb grant", 32'(grant), 32'h1);
    req = '0;
    tick();
    chk("rb num2", 32'(number), 32'd2);
    tick();
    chk("rb num3", 32'(number), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rb async", 4'd0);
    chk("rb done_id", 32'(done_id), 32'd0);
    tick();
    tick();
    chk_idle("rb held", 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk_idle("rb release", 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
